// File: rtl/poly_result_writer.sv
// Streams a captured 256-coefficient polynomial out as 64 four-coefficient words.
// Optional round-to-10-bit compression of each coefficient before packing.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a rising edge of mul_done; capture on that edge
//   WRITE | presenting beat `beat`; advances on we_o & mem_ready
//   DONE  | one-cycle completion pulse, then back to IDLE
module poly_result_writer #(
    parameter int ROUND = 0,
    parameter int H     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mul_done,
    input  logic [3327:0] final_result,
    input  logic          mem_ready,
    output logic          we_o,
    output logic [5:0]    addr_o,
    output logic [51:0]   wdata_o,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           mul_done_q;
    logic [5:0]     beat;
    logic [3327:0]  buffer;
    logic [51:0]    packed_word;
    logic           trigger;
    logic           accept;

    assign trigger = mul_done & ~mul_done_q;
    assign accept  = (state == WRITE) & mem_ready;

    function automatic logic [9:0] round_coef(input logic [12:0] c);
        logic [12:0] s;
        s = c + 13'(H);
        return s[12:3];
    endfunction

    // The current beat always sits in the low 52 bits of the shifting buffer.
    generate
        if (ROUND == 0) begin : g_raw
            assign packed_word = buffer[51:0];
        end else begin : g_round
            logic [39:0] rounded;
            for (genvar k = 0; k < 4; k++) begin : g_coef
                assign rounded[10*k +: 10] = round_coef(buffer[13*k +: 13]);
            end
            assign packed_word = {12'd0, rounded};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = WRITE;
            WRITE:   if (accept && beat == 6'd63) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        we_o    = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        wdata_o = '0;
        addr_o  = beat;
        case (state)
            WRITE: begin
                we_o    = 1'b1;
                busy_o  = 1'b1;
                wdata_o = packed_word;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // Counter saturates at 63 so the address never wraps inside a run.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_done_q <= 1'b0;
            beat       <= 6'd0;
            buffer     <= '0;
        end else begin
            mul_done_q <= mul_done;
            if (state == IDLE && trigger) begin
                buffer <= final_result;
                beat   <= 6'd0;
            end else if (accept) begin
                buffer <= buffer >> 52;
                if (beat != 6'd63) begin
                    beat <= beat + 6'd1;
                end
            end
        end
    end

endmodule
